// File: rtl/im_loader.sv
// Boot loader: parses a framed image (A5, count, big-endian words, byte-sum
// checksum) from the UART byte stream and writes it into instruction memory.
module im_loader #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [7:0]        cnt_hi;
  logic [15:0]       word_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        sum;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sh;
  logic [TW-1:0]     timer;

  logic [15:0] cnt_new;
  logic        last_word;
  logic        in_frame;
  logic        timed_out;

  assign cnt_new   = {cnt_hi, rx_data};
  assign last_word = (32'(wr_addr) == (32'(word_cnt) - 32'd1));
  assign in_frame  = state inside {S_CNT_HI, S_CNT_LO, S_DATA, S_CHK};
  // The idle counter only runs inside a frame and restarts on every byte.
  assign timed_out = in_frame && !rx_vld && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt_hi    <= '0;
      word_cnt  <= '0;
      wr_addr   <= '0;
      sum       <= '0;
      byte_idx  <= '0;
      word_sh   <= '0;
      timer     <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (rx_vld || !in_frame) timer <= '0;
      else                     timer <= timer + TW'(1);

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_vld && rx_data == 8'hA5) begin
            state     <= S_CNT_HI;
            done      <= 1'b0;
            err       <= 1'b0;
            sum       <= '0;
            wr_addr   <= '0;
            byte_idx  <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_CNT_HI: begin
          if (rx_vld) begin
            cnt_hi <= rx_data;
            state  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (rx_vld) begin
            word_cnt <= cnt_new;
            if (cnt_new == 16'd0 || 32'(cnt_new) > MAX_WORDS) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_vld) begin
            word_sh  <= {word_sh[15:0], rx_data};
            sum      <= sum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              im_we    <= 1'b1;
              im_addr  <= wr_addr;
              im_wdata <= {word_sh, rx_data};
              wr_addr  <= wr_addr + ADDR_W'(1);
              if (last_word) state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (rx_vld) begin
            busy <= 1'b0;
            if (rx_data == sum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A stalled frame is abandoned; the CPU stays held in reset.
      if (timed_out) begin
        state <= S_ERR;
        err   <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: frames are built from word lists and the
// expected writes, checksum and outcome are derived from the frame rules.
module tb_im_loader;

  localparam int ADDR_W    = 14;
  localparam int MAX_WORDS = 1024;
  localparam int TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_vld = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_vld(rx_vld), .rx_data(rx_data),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] words[$];
  int          exp_cyc[$];
  int          cyc = 0;
  int          last_vld_cyc = 0;
  int          tests_run = 0;
  int          fails = 0;

  // Records every memory write together with the edge on which it appeared.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (im_we === 1'b1) wr_q.push_back(wr_t'{cyc, im_addr, im_wdata});
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_vld  = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    last_vld_cyc = cyc;
    rx_vld = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (words[i]) s += words[i][31:24] + words[i][23:16] + words[i][15:8] + words[i][7:0];
    return 8'(s % 256);
  endfunction

  task automatic send_frame(input int max_gap, input bit with_sync, input bit with_chk,
                            input logic [7:0] chk);
    int          n;
    logic [31:0] w;
    n = words.size();
    wr_q.delete();
    exp_cyc.delete();
    if (with_sync) send_byte(8'hA5, int'($urandom_range(max_gap, 0)));
    send_byte(8'(n >> 8), int'($urandom_range(max_gap, 0)));
    send_byte(8'(n), int'($urandom_range(max_gap, 0)));
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[31-8*b -: 8],
                  (i == n - 1 && b == 3 && !with_chk) ? 0 : int'($urandom_range(max_gap, 0)));
        if (b == 3) exp_cyc.push_back(last_vld_cyc);
      end
    end
    if (with_chk) send_byte(chk, 0);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rx_vld = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({im_we, im_addr, im_wdata, cpu_rst_n, busy, done, err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_values: got we=%b addr=%h data=%h cpu_rst_n=%b busy=%b done=%b err=%b, expected all 0",
               im_we, im_addr, im_wdata, cpu_rst_n, busy, done, err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({cpu_rst_n, busy, done, err} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL after_reset_idle: got cpu_rst_n=%b busy=%b done=%b err=%b, expected 0000",
               cpu_rst_n, busy, done, err);
    end
  endtask

  task automatic test_noise_idle();
    logic [7:0] noise [3] = '{8'h00, 8'hFF, 8'h3C};
    wr_q.delete();
    foreach (noise[i]) send_byte(noise[i], 1);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, err, cpu_rst_n} !== 4'b0000 || wr_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL idle_noise: got busy=%b done=%b err=%b cpu_rst_n=%b writes=%0d, expected 0000 and 0 writes",
               busy, done, err, cpu_rst_n, wr_q.size());
    end
  endtask

  task automatic test_nominal();
    int bad = 0;
    words = '{32'h12345678, 32'hDEADBEEF};
    send_frame(2, 1, 0, 8'h00);
    @(negedge clk);
    tests_run++;
    if ({done, err, cpu_rst_n, busy} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL nominal_before_chk: got done=%b err=%b cpu_rst_n=%b busy=%b, expected 0001",
               done, err, cpu_rst_n, busy);
    end
    foreach (words[i])
      if (i >= wr_q.size() || wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== words[i] ||
          wr_q[i].cyc != exp_cyc[i]) bad++;
    tests_run++;
    if (bad != 0 || wr_q.size() != words.size()) begin
      fails++;
      $display("[TB] FAIL nominal_writes: got %0d writes (%0d wrong), expected %0d", wr_q.size(), bad, words.size());
    end
    tests_run++;
    if (wr_q.size() < 1 || wr_q[0].data !== 32'h12345678 || wr_q[0].addr !== '0) begin
      fails++;
      $display("[TB] FAIL nominal_first_word: got %0d writes, expected 12345678 at addr 0", wr_q.size());
    end
    send_byte(model_sum(), 0);
    tests_run++;
    if ({done, err, cpu_rst_n, busy} !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL nominal_done: got done=%b err=%b cpu_rst_n=%b busy=%b, expected 1010",
               done, err, cpu_rst_n, busy);
    end
    tests_run++;
    if (im_addr !== ADDR_W'(1) || im_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("[TB] FAIL nominal_hold: got addr=%h data=%h, expected 0001 deadbeef", im_addr, im_wdata);
    end
  endtask

  task automatic test_bad_checksum();
    int bad = 0;
    words = '{32'h12345678, 32'hDEADBEEF};
    send_frame(1, 1, 1, model_sum() + 8'd1);
    tests_run++;
    if ({done, err, cpu_rst_n, busy} !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL badchk_status: got done=%b err=%b cpu_rst_n=%b busy=%b, expected 0100",
               done, err, cpu_rst_n, busy);
    end
    @(negedge clk);
    foreach (words[i])
      if (i >= wr_q.size() || wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== words[i]) bad++;
    tests_run++;
    if (bad != 0 || wr_q.size() != words.size()) begin
      fails++;
      $display("[TB] FAIL badchk_writes: got %0d writes (%0d wrong), expected %0d", wr_q.size(), bad, words.size());
    end
  endtask

  task automatic test_count_bounds();
    int bad = 0;
    wr_q.delete();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    tests_run++;
    if ({err, busy, done} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL count_zero: got err=%b busy=%b done=%b, expected 100", err, busy, done);
    end
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h01, 0);
    tests_run++;
    if ({err, busy, done} !== 3'b100) begin
      fails++;
      $display("[TB] FAIL count_1025: got err=%b busy=%b done=%b, expected 100", err, busy, done);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (wr_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL count_no_writes: got %0d writes, expected 0", wr_q.size());
    end
    words.delete();
    for (int i = 0; i < MAX_WORDS; i++) words.push_back(32'h0);
    send_frame(0, 1, 1, model_sum());
    tests_run++;
    if ({done, err, cpu_rst_n} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL count_1024_done: got done=%b err=%b cpu_rst_n=%b, expected 101", done, err, cpu_rst_n);
    end
    @(negedge clk);
    foreach (words[i])
      if (i >= wr_q.size() || wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== 32'h0 ||
          wr_q[i].cyc != exp_cyc[i]) bad++;
    tests_run++;
    if (bad != 0 || wr_q.size() != MAX_WORDS || wr_q[wr_q.size()-1].addr !== ADDR_W'(1023)) begin
      fails++;
      $display("[TB] FAIL count_1024_writes: got %0d writes (%0d wrong), expected 1024 ending at 1023",
               wr_q.size(), bad);
    end
  endtask

  task automatic test_resync();
    int bad = 0;
    logic [7:0] noise [3] = '{8'h00, 8'hFF, 8'h3C};
    foreach (noise[i]) send_byte(noise[i], 0);
    tests_run++;
    if ({done, busy, cpu_rst_n} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL resync_noise: got done=%b busy=%b cpu_rst_n=%b, expected 101", done, busy, cpu_rst_n);
    end
    words = '{$urandom};
    send_frame(2, 1, 1, model_sum());
    tests_run++;
    if ({done, err, cpu_rst_n} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL resync_one_word: got done=%b err=%b cpu_rst_n=%b, expected 101", done, err, cpu_rst_n);
    end
    words = '{$urandom, $urandom};
    wr_q.delete();
    send_byte(8'hA5, 0);
    tests_run++;
    if ({done, cpu_rst_n, busy} !== 3'b001) begin
      fails++;
      $display("[TB] FAIL resync_sync_clears: got done=%b cpu_rst_n=%b busy=%b, expected 001", done, cpu_rst_n, busy);
    end
    send_frame(1, 0, 1, model_sum());
    tests_run++;
    if (done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL resync_second_done: got done=%b, expected 1", done);
    end
    @(negedge clk);
    foreach (words[i])
      if (i >= wr_q.size() || wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== words[i]) bad++;
    tests_run++;
    if (bad != 0 || wr_q.size() != words.size()) begin
      fails++;
      $display("[TB] FAIL resync_writes: got %0d writes (%0d wrong), expected %0d", wr_q.size(), bad, words.size());
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    wr_q.delete();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'($urandom), 0); send_byte(8'($urandom), 0);
    // err must rise on exactly the TIMEOUT-th idle edge, not earlier.
    for (int j = 1; j <= TIMEOUT; j++) begin
      @(posedge clk);
      #2;
      if (err !== (j == TIMEOUT)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL timeout_edge: got %0d idle edges with wrong err, expected 0 (err=%b)", bad, err);
    end
    tests_run++;
    if ({busy, done, cpu_rst_n} !== 3'b000 || wr_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL timeout_status: got busy=%b done=%b cpu_rst_n=%b writes=%0d, expected 000 and 0",
               busy, done, cpu_rst_n, wr_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    words = '{$urandom | 32'h1, $urandom, $urandom};
    send_frame(0, 1, 0, 8'h00);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({im_we, im_addr, im_wdata, cpu_rst_n, busy, done, err} !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_async: got we=%b addr=%h data=%h cpu_rst_n=%b busy=%b done=%b err=%b, expected all 0",
               im_we, im_addr, im_wdata, cpu_rst_n, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    words = '{$urandom, $urandom};
    send_frame(1, 1, 1, model_sum());
    tests_run++;
    if ({done, err, cpu_rst_n} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL midreset_reload: got done=%b err=%b cpu_rst_n=%b, expected 101", done, err, cpu_rst_n);
    end
    @(negedge clk);
    foreach (words[i])
      if (i >= wr_q.size() || wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== words[i]) bad++;
    tests_run++;
    if (bad != 0 || wr_q.size() != words.size()) begin
      fails++;
      $display("[TB] FAIL midreset_writes: got %0d writes (%0d wrong), expected %0d", wr_q.size(), bad, words.size());
    end
  endtask

  task automatic test_back_to_back();
    int         n;
    int         bad;
    bit         corrupt;
    logic [7:0] chk;
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(6, 1));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      corrupt = ($urandom_range(2, 0) == 0);
      chk = model_sum();
      if (corrupt) chk = chk + 8'd1;
      send_frame((f % 2) * 2, 1, 1, chk);
      tests_run++;
      if ({done, err, cpu_rst_n, busy} !== {~corrupt, corrupt, ~corrupt, 1'b0}) begin
        fails++;
        $display("[TB] FAIL b2b_status frame %0d: got done=%b err=%b cpu_rst_n=%b busy=%b, expected corrupt=%b",
                 f, done, err, cpu_rst_n, busy, corrupt);
      end
      @(negedge clk);
      bad = 0;
      foreach (words[i])
        if (i >= wr_q.size() || wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== words[i] ||
            wr_q[i].cyc != exp_cyc[i]) bad++;
      tests_run++;
      if (bad != 0 || wr_q.size() != words.size()) begin
        fails++;
        $display("[TB] FAIL b2b_writes frame %0d: got %0d writes (%0d wrong), expected %0d",
                 f, wr_q.size(), bad, words.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_noise_idle();
    test_nominal();
    test_bad_checksum();
    test_count_bounds();
    test_resync();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
